// File: rtl/cpu_bus_pkg.sv
// ---------------------------------------------------------------------------
// cpu_bus_pkg
// Shared types and constants for the 8-bit CPU memory bus.
//   resp_state_t : responder FSM states (IDLE, WAIT, RESP, DONE)
//   WAIT_CNT_W   : width of the wait-state down-counter (supports 0..15)
//   CPU_ADDR_W / CPU_DATA_W : default bus widths
//   wait_load()  : counter preload value for a given wait-state count
// ---------------------------------------------------------------------------
package cpu_bus_pkg;

    localparam int CPU_ADDR_W = 8;
    localparam int CPU_DATA_W = 8;
    localparam int WAIT_CNT_W = 4;
    localparam int WAIT_MAX   = (1 << WAIT_CNT_W) - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } resp_state_t;

    // The counter counts WAIT_CYCLES-1 down to 0, so a zero-wait build
    // never loads it and skips WAIT entirely.
    function automatic logic [WAIT_CNT_W-1:0] wait_load(input int cycles);
        if (cycles > 0) begin
            return WAIT_CNT_W'(cycles - 1);
        end
        return '0;
    endfunction

endpackage

// File: rtl/cpu_mem_responder_if.sv
// ---------------------------------------------------------------------------
// cpu_mem_responder_if
// Request/response channel between the CPU (master) and the memory
// responder (slave).
//   req_valid/req_ready : request handshake, accept on both high
//   req_we/req_addr/req_wdata : request fields, sampled at accept
//   rsp_valid/rsp_rdata : one-cycle completion pulse with read data
// ---------------------------------------------------------------------------
interface cpu_mem_responder_if
    import cpu_bus_pkg::*;
#(
    parameter int ADDR_W = CPU_ADDR_W,
    parameter int DATA_W = CPU_DATA_W
) ();

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );

endinterface

// File: rtl/mem_ram_sp.sv
// ---------------------------------------------------------------------------
// mem_ram_sp
// Single-port synchronous RAM, 2**ADDR_W x DATA_W, read-first.
//   clk   : clock
//   we    : write enable
//   addr  : shared read/write address
//   wdata : write data
//   rdata : registered read data (old contents on a write cycle)
// Contents are deliberately not reset.
// ---------------------------------------------------------------------------
module mem_ram_sp
    import cpu_bus_pkg::*;
#(
    parameter int ADDR_W = CPU_ADDR_W,
    parameter int DATA_W = CPU_DATA_W
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [0:(1 << ADDR_W)-1];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata_q <= mem[addr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/cpu_mem_responder.sv
// ---------------------------------------------------------------------------
// cpu_mem_responder
// Memory-side responder for the 8-bit CPU bus. Accepts one access at a
// time, waits WAIT_CYCLES, touches the RAM in RESP and pulses rsp_valid in
// DONE. A side load port preloads bytes while the responder is idle.
//   clk       : clock, rising edge
//   reset     : synchronous, active-low
//   bus       : cpu_mem_responder_if slave (request/response channel)
//   ld_en/ld_addr/ld_data : preload strobe, address, data
//   ld_ok     : previous cycle's ld_en was written to memory
//   acc_count : completed accesses, saturating at all-ones
// ---------------------------------------------------------------------------
module cpu_mem_responder
    import cpu_bus_pkg::*;
#(
    parameter int ADDR_W      = CPU_ADDR_W,
    parameter int DATA_W      = CPU_DATA_W,
    parameter int WAIT_CYCLES = 2,
    parameter int CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    cpu_mem_responder_if.slave   bus,
    input  logic                 ld_en,
    input  logic [ADDR_W-1:0]    ld_addr,
    input  logic [DATA_W-1:0]    ld_data,
    output logic                 ld_ok,
    output logic [CNT_W-1:0]     acc_count
);

    generate
        if (WAIT_CYCLES < 0 || WAIT_CYCLES > WAIT_MAX) begin : g_bad_wait
            $error("cpu_mem_responder: WAIT_CYCLES must be in 0..15");
        end
    endgenerate

    localparam logic [WAIT_CNT_W-1:0] WAIT_PRELOAD = wait_load(WAIT_CYCLES);

    resp_state_t           state_q, state_d;
    logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic                  we_q, we_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  ld_ok_q, ld_ok_d;
    logic [CNT_W-1:0]      acc_count_q, acc_count_d;

    logic                  ld_take;
    logic                  accept;
    logic                  ram_we;
    logic [ADDR_W-1:0]     ram_addr;
    logic [DATA_W-1:0]     ram_wdata;
    logic [DATA_W-1:0]     ram_rdata;

    // Loads win over requests: ld_en in IDLE drops req_ready so the CPU
    // request simply waits a cycle.
    assign ld_take       = reset & ld_en & (state_q == IDLE);
    assign bus.req_ready = reset & ~ld_en & (state_q == IDLE);
    assign accept        = bus.req_valid & bus.req_ready;

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        acc_count_d = acc_count_q;
        rsp_valid_d = 1'b0;
        ld_ok_d     = ld_take;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    we_d    = bus.req_we;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    if (WAIT_CYCLES > 0) begin
                        state_d    = WAIT;
                        wait_cnt_d = WAIT_PRELOAD;
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            WAIT: begin
                if (wait_cnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q - 1'b1;
                end
            end
            RESP: begin
                // RAM is accessed this cycle; its registered output lines
                // up with the rsp_valid pulse in DONE.
                state_d     = DONE;
                rsp_valid_d = 1'b1;
            end
            DONE: begin
                state_d = IDLE;
                if (acc_count_q != '1) begin
                    acc_count_d = acc_count_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            wait_cnt_q  <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            ld_ok_q     <= 1'b0;
            acc_count_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            ld_ok_q     <= ld_ok_d;
            acc_count_q <= acc_count_d;
        end
    end

    // Single RAM port: latched request in RESP, load path otherwise.
    // The write is gated by reset so an abandoned access never commits.
    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = ld_addr;
        ram_wdata = ld_data;
        if (state_q == RESP) begin
            ram_addr  = addr_q;
            ram_wdata = wdata_q;
            ram_we    = reset & we_q;
        end else if (ld_take) begin
            ram_we = 1'b1;
        end
    end

    mem_ram_sp #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = (rsp_valid_q && !we_q) ? ram_rdata : '0;
    assign ld_ok         = ld_ok_q;
    assign acc_count     = acc_count_q;

endmodule

// File: tb/tb_cpu_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_cpu_mem_responder
// Two responders: dut_a (WAIT_CYCLES=2, 16-bit counter) for the functional
// scenarios and dut_b (WAIT_CYCLES=0, 4-bit counter) for zero-wait latency
// and counter saturation. Expected read data comes from a byte-array model
// and is queued at accept, then popped when rsp_valid arrives.
// ---------------------------------------------------------------------------
module tb_cpu_mem_responder;

    localparam int WAIT_A = 2;
    localparam int WAIT_B = 0;
    localparam int LIMIT  = 40;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    cpu_mem_responder_if #(.ADDR_W(8), .DATA_W(8)) bus_a ();
    cpu_mem_responder_if #(.ADDR_W(8), .DATA_W(8)) bus_b ();

    logic        ld_en_a, ld_en_b;
    logic [7:0]  ld_addr_a, ld_data_a, ld_addr_b, ld_data_b;
    logic        ld_ok_a, ld_ok_b;
    logic [15:0] acc_a;
    logic [3:0]  acc_b;

    cpu_mem_responder #(.ADDR_W(8), .DATA_W(8), .WAIT_CYCLES(WAIT_A), .CNT_W(16)) dut_a (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus_a.slave),
        .ld_en     (ld_en_a),
        .ld_addr   (ld_addr_a),
        .ld_data   (ld_data_a),
        .ld_ok     (ld_ok_a),
        .acc_count (acc_a)
    );

    cpu_mem_responder #(.ADDR_W(8), .DATA_W(8), .WAIT_CYCLES(WAIT_B), .CNT_W(4)) dut_b (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus_b.slave),
        .ld_en     (ld_en_b),
        .ld_addr   (ld_addr_b),
        .ld_data   (ld_data_b),
        .ld_ok     (ld_ok_b),
        .acc_count (acc_b)
    );

    int         n_run  = 0;
    int         n_fail = 0;
    int         acc_exp_a = 0;
    int         acc_exp_b = 0;
    logic [7:0] mem_a [0:255];
    logic [7:0] mem_b [0:255];
    logic [7:0] sb_q [$];

    // One access on dut_a. Starts in the low clock phase, ends at the
    // negedge right after the rsp_valid cycle (responder back in IDLE).
    task automatic access_a(input logic we, input logic [7:0] addr, input logic [7:0] wdata,
                            input bit ld_in_wait, output int acc_wait);
        int         lat;
        logic [7:0] exp;
        bus_a.req_valid = 1'b1;
        bus_a.req_we    = we;
        bus_a.req_addr  = addr;
        bus_a.req_wdata = wdata;
        #1;
        acc_wait = 0;
        while (bus_a.req_ready !== 1'b1 && acc_wait < LIMIT) begin
            @(negedge clk); #1;
            acc_wait++;
        end
        n_run++;
        if (acc_wait >= LIMIT) begin
            n_fail++;
            $display("FAIL a_accept_timeout: waited %0d cycles, required < %0d", acc_wait, LIMIT);
        end
        exp = we ? 8'h00 : mem_a[addr];
        sb_q.push_back(exp);
        if (we) mem_a[addr] = wdata;
        @(negedge clk);
        // Scramble the fields after accept; the latched copy must be used.
        bus_a.req_valid = 1'b0;
        bus_a.req_we    = ~we;
        bus_a.req_addr  = ~addr;
        bus_a.req_wdata = 8'($urandom);
        lat = 1;
        while (bus_a.rsp_valid !== 1'b1 && lat < LIMIT) begin
            if (ld_in_wait && lat == 1) begin
                ld_en_a   = 1'b1;
                ld_addr_a = addr;
                ld_data_a = ~mem_a[addr];
            end
            if (ld_in_wait && lat == 2) begin
                ld_en_a = 1'b0;
                n_run++;
                if (ld_ok_a !== 1'b0) begin
                    n_fail++;
                    $display("FAIL a_ld_ok_in_wait: got %b, required 0", ld_ok_a);
                end
            end
            @(negedge clk);
            lat++;
        end
        ld_en_a = 1'b0;
        n_run++;
        if (lat != WAIT_A + 2) begin
            n_fail++;
            $display("FAIL a_latency: got %0d cycles, required %0d", lat, WAIT_A + 2);
        end
        exp = sb_q.pop_front();
        n_run++;
        if (bus_a.rsp_rdata !== exp) begin
            n_fail++;
            $display("FAIL a_rdata addr=0x%02h: got 0x%02h, required 0x%02h", addr, bus_a.rsp_rdata, exp);
        end
        if (acc_exp_a < 65535) acc_exp_a++;
        $display("[TB] A %s addr=0x%02h wdata=0x%02h rdata=0x%02h latency=%0d",
                 we ? "WR" : "RD", addr, wdata, bus_a.rsp_rdata, lat);
        @(negedge clk);
        n_run++;
        if (bus_a.rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL a_rsp_pulse: rsp_valid got %b one cycle later, required 0", bus_a.rsp_valid);
        end
        n_run++;
        if (acc_a !== 16'(acc_exp_a)) begin
            n_fail++;
            $display("FAIL a_acc_count: got %0d, required %0d", acc_a, acc_exp_a);
        end
    endtask

    task automatic access_b(input logic we, input logic [7:0] addr, input logic [7:0] wdata);
        int         waited;
        int         lat;
        logic [7:0] exp;
        bus_b.req_valid = 1'b1;
        bus_b.req_we    = we;
        bus_b.req_addr  = addr;
        bus_b.req_wdata = wdata;
        #1;
        waited = 0;
        while (bus_b.req_ready !== 1'b1 && waited < LIMIT) begin
            @(negedge clk); #1;
            waited++;
        end
        exp = we ? 8'h00 : mem_b[addr];
        sb_q.push_back(exp);
        if (we) mem_b[addr] = wdata;
        @(negedge clk);
        bus_b.req_valid = 1'b0;
        bus_b.req_addr  = ~addr;
        lat = 1;
        while (bus_b.rsp_valid !== 1'b1 && lat < LIMIT) begin
            @(negedge clk);
            lat++;
        end
        n_run++;
        if (lat != WAIT_B + 2) begin
            n_fail++;
            $display("FAIL b_latency: got %0d cycles, required %0d", lat, WAIT_B + 2);
        end
        exp = sb_q.pop_front();
        n_run++;
        if (bus_b.rsp_rdata !== exp) begin
            n_fail++;
            $display("FAIL b_rdata addr=0x%02h: got 0x%02h, required 0x%02h", addr, bus_b.rsp_rdata, exp);
        end
        if (acc_exp_b < 15) acc_exp_b++;
        $display("[TB] B %s addr=0x%02h wdata=0x%02h rdata=0x%02h latency=%0d",
                 we ? "WR" : "RD", addr, wdata, bus_b.rsp_rdata, lat);
        @(negedge clk);
        n_run++;
        if (acc_b !== 4'(acc_exp_b)) begin
            n_fail++;
            $display("FAIL b_acc_count: got %0d, required %0d", acc_b, acc_exp_b);
        end
    endtask

    task automatic load_a(input logic [7:0] addr, input logic [7:0] data);
        ld_en_a   = 1'b1;
        ld_addr_a = addr;
        ld_data_a = data;
        @(negedge clk);
        ld_en_a = 1'b0;
        mem_a[addr] = data;
        n_run++;
        if (ld_ok_a !== 1'b1) begin
            n_fail++;
            $display("FAIL a_ld_ok: got %b, required 1", ld_ok_a);
        end
        $display("[TB] A LD addr=0x%02h data=0x%02h ld_ok=%b", addr, data, ld_ok_a);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus_a.req_valid = 1'b1; bus_a.req_we = 1'b1; bus_a.req_addr = 8'h10; bus_a.req_wdata = 8'h99;
        bus_b.req_valid = 1'b1; bus_b.req_we = 1'b0; bus_b.req_addr = 8'h00; bus_b.req_wdata = 8'h00;
        ld_en_a = 1'b0; ld_addr_a = '0; ld_data_a = '0;
        ld_en_b = 1'b0; ld_addr_b = '0; ld_data_b = '0;
        repeat (2) begin
            @(negedge clk);
            n_run++;
            if (bus_a.req_ready !== 1'b0 || bus_b.req_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_ready: got a=%b b=%b, required 0", bus_a.req_ready, bus_b.req_ready);
            end
            n_run++;
            if (bus_a.rsp_valid !== 1'b0 || acc_a !== 16'd0 || ld_ok_a !== 1'b0 || bus_a.rsp_rdata !== 8'h00) begin
                n_fail++;
                $display("FAIL reset_outputs: got rsp_valid=%b acc=%0d ld_ok=%b rdata=0x%02h, required 0/0/0/0",
                         bus_a.rsp_valid, acc_a, ld_ok_a, bus_a.rsp_rdata);
            end
            n_run++;
            if (acc_b !== 4'd0) begin
                n_fail++;
                $display("FAIL reset_acc_b: got %0d, required 0", acc_b);
            end
        end
        reset = 1'b1;
        bus_a.req_valid = 1'b0;
        bus_b.req_valid = 1'b0;
        repeat (WAIT_A + 4) begin
            @(negedge clk);
            n_run++;
            if (bus_a.rsp_valid !== 1'b0 || bus_a.req_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_no_accept: got rsp_valid=%b req_ready=%b, required 0/1",
                         bus_a.rsp_valid, bus_a.req_ready);
            end
        end
        $display("[TB] reset released, responder idle");
    endtask

    task automatic test_load_read();
        int w;
        load_a(8'h10, 8'hA5);
        access_a(1'b0, 8'h10, 8'h00, 1'b0, w);
    endtask

    task automatic test_back_to_back();
        int w;
        access_a(1'b1, 8'h3F, 8'h5C, 1'b0, w);
        access_a(1'b0, 8'h3F, 8'h00, 1'b0, w);
        n_run++;
        if (w != 0) begin
            n_fail++;
            $display("FAIL b2b_accept: read waited %0d cycles, required 0", w);
        end
    endtask

    task automatic test_collision();
        int w;
        ld_en_a = 1'b1; ld_addr_a = 8'h40; ld_data_a = 8'h77;
        bus_a.req_valid = 1'b1; bus_a.req_we = 1'b0; bus_a.req_addr = 8'h40; bus_a.req_wdata = 8'h00;
        #1;
        n_run++;
        if (bus_a.req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL collision_ready: got %b, required 0", bus_a.req_ready);
        end
        @(negedge clk);
        ld_en_a = 1'b0;
        mem_a[8'h40] = 8'h77;
        n_run++;
        if (ld_ok_a !== 1'b1) begin
            n_fail++;
            $display("FAIL collision_ld_ok: got %b, required 1", ld_ok_a);
        end
        access_a(1'b0, 8'h40, 8'h00, 1'b1, w);
        n_run++;
        if (w != 0) begin
            n_fail++;
            $display("FAIL collision_accept: waited %0d cycles after load, required 0", w);
        end
        access_a(1'b0, 8'h40, 8'h00, 1'b0, w);
    endtask

    task automatic test_reset_mid_op();
        int w;
        load_a(8'h20, 8'h11);
        bus_a.req_valid = 1'b1; bus_a.req_we = 1'b1; bus_a.req_addr = 8'h20; bus_a.req_wdata = 8'hFF;
        #1;
        n_run++;
        if (bus_a.req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midop_ready: got %b, required 1", bus_a.req_ready);
        end
        @(negedge clk);
        bus_a.req_valid = 1'b0;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        acc_exp_a = 0;
        repeat (WAIT_A + 4) begin
            n_run++;
            if (bus_a.rsp_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL midop_no_rsp: got rsp_valid=%b, required 0", bus_a.rsp_valid);
            end
            @(negedge clk);
        end
        n_run++;
        if (acc_a !== 16'd0) begin
            n_fail++;
            $display("FAIL midop_acc: got %0d, required 0", acc_a);
        end
        $display("[TB] A write 0x20 abandoned by reset");
        access_a(1'b0, 8'h20, 8'h00, 1'b0, w);
    endtask

    task automatic test_wait0_saturation();
        for (int i = 0; i < 10; i++) begin
            access_b(1'b1, 8'(8'h80 + i), 8'($urandom));
        end
        for (int i = 0; i < 9; i++) begin
            access_b(1'b0, 8'(8'h80 + i), 8'h00);
        end
        n_run++;
        if (acc_b !== 4'hF) begin
            n_fail++;
            $display("FAIL b_saturation: got 0x%0h, required 0xf", acc_b);
        end
    endtask

    initial begin
        test_reset();
        test_load_read();
        test_back_to_back();
        test_collision();
        test_reset_mid_op();
        test_wait0_saturation();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
